serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing d = a - b one bit per clock.
- Uses a single full_adder instance, a carry flip-flop and shift registers, with a start/done handshake.
- Counterpart to the parallel ripple-carry adder: subtraction instead of addition, trading area for N-cycle latency.
- Sits beside the parallel adder in the datapath library, for area-constrained ALU paths.

Parameters:
- N, 32, operand/result width in bits (N >= 2).
- CW, $clog2(N), bit-counter width.

Ports:
- clk       input   1   rising-edge clock
- rst_n     input   1   asynchronous active-low reset
- start     input   1   request; sampled only in IDLE or DONE
- a         input   N   minuend, captured on accepted start
- b         input   N   subtrahend, captured on accepted start
- busy      output  1   high while in RUN
- done      output  1   one-cycle pulse; result outputs valid from this cycle
- d         output  N   difference a - b modulo 2^N
- borrow    output  1   1 when a < b unsigned (inverse of final carry)
- overflow  output  1   signed overflow of a - b
- zero      output  1   1 when d == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, d=0, borrow=0, overflow=0, zero=0, counter=0, carry flip-flop=0.
- Arithmetic uses two's complement: d = a + ~b + 1.
- On accepted start:
  - sa <= a, sb <= ~b
  - carry <= 1, count <= 0
  - state RUN
- States:
  - IDLE: busy=0, done=0. start=1 goes to RUN.
  - RUN: busy=1. Each edge feeds full_adder(sa[0], sb[0], carry) → (s, co).
    - Shift sa and sb right by one.
    - Shift s into the MSB of result shift register sr.
    - carry <= co, count++.
    - On the edge where count == N-1 (last bit):
      - d <= {s, sr[N-1:1]}
      - borrow <= ~co
      - overflow <= carry ^ co (carry into MSB XOR carry out)
      - zero <= (final d == 0)
      - state DONE
  - DONE: done=1 for exactly one cycle, busy=0. start=1 goes directly to RUN (back-to-back allowed). Otherwise go to IDLE.
- Latency:
  - start sampled at edge E0.
  - Bits processed on edges E1..EN.
  - done high in the cycle after EN.
  - Throughput is N+1 cycles per operation with back-to-back starts.
- Result hold: d, borrow, overflow and zero hold their values until the next completion. They are not disturbed while the next operation runs.
- Boundary rules:
  - start while busy is ignored; a and b are not re-sampled.
  - a and b may change freely after the accepting edge.
  - rst_n asserted mid-RUN aborts the operation: all state cleared, no done pulse.
  - Counter wraps only via the state transition; no count beyond N-1.
  - Equal operands give d=0, zero=1, borrow=0, overflow=0.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default width constant
- Sub-module: reuse the existing full_adder cell (one instance, named fa0). No other hierarchy.

Test Plan (N=8):
- a=10, b=3, start one cycle → busy for 8 cycles; done at cycle 9 with d=7, borrow=0, overflow=0, zero=0.
- a=3, b=10 → d=0xF9, borrow=1, overflow=0.
- a=0x80, b=0x01 → d=0x7F, borrow=0, overflow=1. Then a=0x7F, b=0xFF → d=0x80, overflow=1, borrow=1.
- Start a=5, b=5; pulse start with a=9, b=1 during RUN → ignored; done gives d=0, zero=1, borrow=0.
- Start a=20, b=4; drop rst_n at cycle 4 for one cycle → no done, all outputs 0. New start a=20, b=4 → d=16 after N+1 cycles.
- start held high continuously with a=100, b=1 → done pulses every 9 cycles; d=99 each time; busy low only in DONE cycles.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   // Default operand width for serial arithmetic units
   localparam int SA_DEFAULT_N = 32;

   // Control state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sa_state_e;

endpackage : serial_arith_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   // Sum and carry of three single-bit inputs
   always_comb begin
      s_o  = a_i ^ b_i ^ ci_i;
      co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
   end

endmodule : full_adder

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b computed LSB first, one bit per
// clock, as a + ~b + 1 through a single full adder and a carry flop.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int N  = SA_DEFAULT_N,
   parameter int CW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] d,
   output logic         borrow,
   output logic         overflow,
   output logic         zero
);

   // Counter value seen on the edge that processes the MSB
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   sa_state_e     state_q;
   logic          busy_q;
   logic          done_q;
   logic [N-1:0]  sa_q;
   logic [N-1:0]  sb_q;
   logic [N-1:0]  sr_q;
   logic          carry_q;
   logic [CW-1:0] count_q;
   logic [N-1:0]  d_q;
   logic          borrow_q;
   logic          overflow_q;
   logic          zero_q;

   logic          fa_s;
   logic          fa_co;
   logic [N-1:0]  sa_d;
   logic [N-1:0]  sb_d;
   logic [N-1:0]  sr_d;
   logic [CW-1:0] count_d;
   logic          accept;
   logic          last_bit;

   // Single adder slice; operands arrive on bit 0 of the shift registers
   full_adder fa0 (
      .a_i  (sa_q[0]),
      .b_i  (sb_q[0]),
      .ci_i (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // Next values of the serial datapath for one RUN step
   always_comb begin
      sa_d     = {1'b0, sa_q[N-1:1]};
      sb_d     = {1'b0, sb_q[N-1:1]};
      sr_d     = {fa_s, sr_q[N-1:1]};
      count_d  = count_q + 1'b1;
      last_bit = (count_q == LAST_BIT);
      // start is only honoured between operations
      accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sa_q       <= '0;
         sb_q       <= '0;
         sr_q       <= '0;
         carry_q    <= 1'b0;
         count_q    <= '0;
         d_q        <= '0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (accept) begin
                  // Load minuend and inverted subtrahend; carry-in of 1
                  // completes the two's complement negation of b
                  sa_q    <= a;
                  sb_q    <= ~b;
                  carry_q <= 1'b1;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            ST_RUN: begin
               sa_q    <= sa_d;
               sb_q    <= sb_d;
               sr_q    <= sr_d;
               carry_q <= fa_co;
               if (last_bit) begin
                  // carry_q is the carry into the MSB here, fa_co the
                  // carry out of it; a missing carry out means a borrow
                  d_q        <= sr_d;
                  borrow_q   <= ~fa_co;
                  overflow_q <= carry_q ^ fa_co;
                  zero_q     <= (sr_d == '0);
                  count_q    <= '0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
               end else begin
                  count_q <= count_d;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               count_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Output mapping
   always_comb begin
      busy     = busy_q;
      done     = done_q;
      d        = d_q;
      borrow   = borrow_q;
      overflow = overflow_q;
      zero     = zero_q;
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N=8.
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] d;
   logic         borrow;
   logic         overflow;
   logic         zero;

   int vectors = 0;
   int miscompares = 0;

   serial_subtractor #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .d        (d),
      .borrow   (borrow),
      .overflow (overflow),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference results from plain integer arithmetic
   task automatic ref_sub(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                          output logic [N-1:0] rd, output logic rbor,
                          output logic rovf, output logic rzero);
      int diff;
      int sdiff;
      diff  = int'(ta) - int'(tb_);
      sdiff = int'($signed(ta)) - int'($signed(tb_));
      rd    = N'(diff);
      rbor  = (ta < tb_);
      rovf  = (sdiff > 127) || (sdiff < -128);
      rzero = (rd == '0);
   endtask

   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input bit glitch_start, input bit check_hold);
      logic [N-1:0] ed;
      logic eb, eo, ez;
      logic [N-1:0] prev_d;
      int cyc;
      int busy_cnt;
      ref_sub(ta, tb_, ed, eb, eo, ez);
      prev_d = d;
      @(negedge clk);
      a = ta; b = tb_; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = N'($urandom); b = N'($urandom);
      cyc = 0;
      busy_cnt = 0;
      while (cyc <= 20) begin
         @(negedge clk);
         cyc++;
         if (done) break;
         if (busy) busy_cnt++;
         if (check_hold && cyc == 4) check("hold_prev_d", 32'(d), 32'(prev_d));
         if (glitch_start && cyc == 3) begin
            a = 8'd9; b = 8'd1; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      check("latency", 32'(cyc), 32'(N + 1));
      check("busy_cycles", 32'(busy_cnt), 32'(N));
      check("d", 32'(d), 32'(ed));
      check("borrow", 32'(borrow), 32'(eb));
      check("overflow", 32'(overflow), 32'(eo));
      check("zero", 32'(zero), 32'(ez));
      check("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("d_after_done", 32'(d), 32'(ed));
   endtask

   initial begin
      logic [N-1:0] last_d;
      bit seen_done;
      bit busy_ok;
      int cyc;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_d", 32'(d), 32'd0);
      check("rst_flags", {29'd0, borrow, overflow, zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op(8'd10, 8'd3, 1'b0, 1'b0);
      run_op(8'd3, 8'd10, 1'b0, 1'b1);
      run_op(8'h80, 8'h01, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 1'b0, 1'b1);
      run_op(8'd5, 8'd5, 1'b1, 1'b1);
      run_op(8'd0, 8'd0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h00, 1'b0, 1'b1);
      run_op(8'h00, 8'hFF, 1'b0, 1'b1);

      // Reset mid-operation aborts with no done pulse
      @(negedge clk);
      a = 8'd20; b = 8'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_d", 32'(d), 32'd0);
      check("abort_flags", {29'd0, borrow, overflow, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      run_op(8'd20, 8'd4, 1'b0, 1'b0);

      // Back-to-back with start held high
      @(negedge clk);
      a = 8'd100; b = 8'd1; start = 1'b1;
      busy_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         while (cyc <= 20) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
         end
         check("b2b_period", 32'(cyc), 32'(N + 1));
         check("b2b_d", 32'(d), 32'd99);
         check("b2b_busy_at_done", 32'(busy), 32'd0);
      end
      check("b2b_busy_high", 32'(busy_ok), 32'd1);
      start = 1'b0;
      repeat (N + 3) @(negedge clk);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         run_op(N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_serial_subtractor
